// File: rtl/ring_switch_allocator_pkg.sv
// Shared NoC types for the ring router switch allocator.
//   noc_port_t    : port index (West/East/Local), also the round-robin pointer type
//   direction_t   : one-hot requested output (bit index = noc_port_t)
//   preamble_t    : head/tail flags of the flit at a FIFO head
//   alloc_state_t : per-output allocation state
package ring_switch_allocator_pkg;

  typedef enum logic [1:0] {
    kWestPort  = 2'd0,
    kEastPort  = 2'd1,
    kLocalPort = 2'd2
  } noc_port_t;

  typedef logic [2:0] direction_t;

  localparam direction_t kGoWest  = 3'b001;
  localparam direction_t kGoEast  = 3'b010;
  localparam direction_t kGoLocal = 3'b100;

  typedef struct packed {
    logic head;
    logic tail;
  } preamble_t;

  localparam logic [2:0] AllPorts = 3'b111;

  typedef enum logic {
    kAllocIdle   = 1'b0,
    kAllocLocked = 1'b1
  } alloc_state_t;

  // Width of a credit counter that must hold 0..depth inclusive.
  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic noc_port_t next_rr_ptr(input noc_port_t p);
    case (p)
      kWestPort: return kEastPort;
      kEastPort: return kLocalPort;
      default:   return kWestPort;
    endcase
  endfunction

  function automatic noc_port_t port_of_onehot(input logic [2:0] oh);
    case (oh)
      3'b010:  return kEastPort;
      3'b100:  return kLocalPort;
      default: return kWestPort;
    endcase
  endfunction

endpackage

// File: rtl/ring_switch_allocator_if.sv
// Allocator handshake bundle between input FIFOs, crossbar and downstream credits.
//   master : upstream side (drives flit presence/route/preamble and credit returns)
//   slave  : allocator side (drives pops, crossbar selects, credit counts, err)
interface ring_switch_allocator_if
  import ring_switch_allocator_pkg::*;
#(
  parameter int unsigned Depth = 4
);
  localparam int unsigned CW = credit_width(Depth);

  logic       [2:0]         in_valid;
  direction_t [2:0]         in_route;
  preamble_t  [2:0]         in_preamble;
  logic       [2:0]         in_pop;
  logic       [2:0]         out_valid;
  noc_port_t  [2:0]         out_sel;
  logic       [2:0]         credit_in;
  logic       [2:0][CW-1:0] credits;
  logic                     err;

  modport master (
    output in_valid, in_route, in_preamble, credit_in,
    input  in_pop, out_valid, out_sel, credits, err
  );

  modport slave (
    input  in_valid, in_route, in_preamble, credit_in,
    output in_pop, out_valid, out_sel, credits, err
  );
endinterface

// File: rtl/ring_switch_allocator_arb.sv
// noc_rr_arbiter3: 3-requester round-robin arbiter.
//   req : request vector (bit = noc_port_t)
//   ptr : highest-priority requester this cycle
//   gnt : one-hot grant (zero when no request)
module noc_rr_arbiter3
  import ring_switch_allocator_pkg::*;
(
  input  logic [2:0] req,
  input  noc_port_t  ptr,
  output logic [2:0] gnt
);
  logic [2:0] rot;
  logic [2:0] rot_gnt;

  // Rotate so the pointer's requester sits at bit 0, pick lowest, rotate back.
  always_comb begin
    case (ptr)
      kEastPort:  rot = {req[0], req[2], req[1]};
      kLocalPort: rot = {req[1], req[0], req[2]};
      default:    rot = req;
    endcase

    if (rot[0])      rot_gnt = 3'b001;
    else if (rot[1]) rot_gnt = 3'b010;
    else if (rot[2]) rot_gnt = 3'b100;
    else             rot_gnt = 3'b000;

    case (ptr)
      kEastPort:  gnt = {rot_gnt[1], rot_gnt[0], rot_gnt[2]};
      kLocalPort: gnt = {rot_gnt[0], rot_gnt[2], rot_gnt[1]};
      default:    gnt = rot_gnt;
    endcase
  end
endmodule

// File: rtl/ring_switch_allocator.sv
// ring_switch_allocator: per-router switch allocator for the ring NoC.
// Round-robin arbitration per output, wormhole lock head->tail, downstream
// credit tracking; pops and crossbar selects are combinational from requests.
//   clk : router clock
//   rst : asynchronous active-low reset
//   bus : allocator handshake (slave modport)
module ring_switch_allocator
  import ring_switch_allocator_pkg::*;
#(
  parameter logic [2:0]  Ports = AllPorts,
  parameter int unsigned Depth = 4
) (
  input logic                    clk,
  input logic                    rst,
  ring_switch_allocator_if.slave bus
);
  localparam int unsigned CW = credit_width(Depth);
  typedef logic [CW-1:0] credit_t;
  localparam credit_t DepthC = credit_t'(Depth);

  alloc_state_t state_q  [3];
  alloc_state_t state_d  [3];
  noc_port_t    owner_q  [3];
  noc_port_t    owner_d  [3];
  noc_port_t    ptr_q    [3];
  noc_port_t    ptr_d    [3];
  credit_t      credit_q [3];
  credit_t      credit_d [3];
  logic         err_q, err_d;

  logic [2:0][2:0] req;      // req[j][i]: input i legally requests output j
  logic [2:0][2:0] elig;
  logic [2:0][2:0] arb_gnt;
  logic [2:0]      bad_in;
  logic [2:0]      head, tail;
  logic [2:0]      pop, ovalid;
  noc_port_t [2:0] osel;

  function automatic logic legal_route(input direction_t r, input int unsigned i);
    logic uturn;
    uturn = (i != 32'd2) && r[i];
    return $onehot(r) && Ports[i] && ((r & Ports) != 3'b000) && !uturn;
  endfunction

  always_comb begin
    req    = '0;
    bad_in = '0;
    head   = '0;
    tail   = '0;
    elig   = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      head[i] = bus.in_preamble[i].head;
      tail[i] = bus.in_preamble[i].tail;
      if (bus.in_valid[i]) begin
        if (legal_route(bus.in_route[i], i)) begin
          for (int unsigned j = 0; j < 3; j++) begin
            req[j][i] = bus.in_route[i][j];
          end
        end else begin
          bad_in[i] = 1'b1;
        end
      end
    end
    for (int unsigned j = 0; j < 3; j++) begin
      if (state_q[j] == kAllocIdle) elig[j] = req[j] & head;
    end
  end

  for (genvar j = 0; j < 3; j++) begin : g_arb
    noc_rr_arbiter3 u_arb (
      .req (elig[j]),
      .ptr (ptr_q[j]),
      .gnt (arb_gnt[j])
    );
  end

  always_comb begin
    noc_port_t win;
    noc_port_t own;
    logic      has_credit;

    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    err_d    = err_q | (|bad_in);
    pop      = '0;
    ovalid   = '0;
    osel     = {kWestPort, kWestPort, kWestPort};

    for (int unsigned j = 0; j < 3; j++) begin
      win        = port_of_onehot(arb_gnt[j]);
      own        = owner_q[j];
      has_credit = (credit_q[j] != '0);

      if (Ports[j]) begin
        if (state_q[j] == kAllocIdle) begin
          if ((req[j] & ~head) != 3'b000) err_d = 1'b1;
          if (has_credit && (arb_gnt[j] != 3'b000)) begin
            ovalid[j] = 1'b1;
            osel[j]   = win;
            pop       = pop | arb_gnt[j];
            ptr_d[j]  = next_rr_ptr(win);
            if (!tail[win]) begin
              state_d[j] = kAllocLocked;
              owner_d[j] = win;
            end
          end
        end else if (req[j][own]) begin
          // Locked: only the owner is considered; other requesters simply stall.
          if (head[own]) begin
            err_d = 1'b1;
          end else if (has_credit) begin
            ovalid[j] = 1'b1;
            osel[j]   = own;
            pop[own]  = 1'b1;
            if (tail[own]) state_d[j] = kAllocIdle;
          end
        end
      end

      if (bus.credit_in[j] && !ovalid[j] && (credit_q[j] == DepthC)) begin
        err_d = 1'b1;
      end else begin
        credit_d[j] = credit_q[j] - credit_t'(ovalid[j]) + credit_t'(bus.credit_in[j]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned j = 0; j < 3; j++) begin
        state_q[j]  <= kAllocIdle;
        owner_q[j]  <= kWestPort;
        ptr_q[j]    <= kWestPort;
        credit_q[j] <= DepthC;
      end
      err_q <= 1'b0;
    end else begin
      for (int unsigned j = 0; j < 3; j++) begin
        state_q[j]  <= state_d[j];
        owner_q[j]  <= owner_d[j];
        ptr_q[j]    <= ptr_d[j];
        credit_q[j] <= credit_d[j];
      end
      err_q <= err_d;
    end
  end

  assign bus.in_pop    = pop;
  assign bus.out_valid = ovalid;
  assign bus.out_sel   = osel;
  assign bus.err       = err_q;
  for (genvar j = 0; j < 3; j++) begin : g_cred
    assign bus.credits[j] = credit_q[j];
  end
endmodule

// File: tb/tb_ring_switch_allocator.sv
// Directed self-checking bench for ring_switch_allocator (Depth=4, all ports enabled).
module tb_ring_switch_allocator;
  import ring_switch_allocator_pkg::*;

  logic clk;
  logic rst;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  ring_switch_allocator_if #(.Depth(4)) bus ();

  ring_switch_allocator #(.Ports(3'b111), .Depth(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.in_valid    = '0;
    bus.in_route    = '0;
    bus.in_preamble = '0;
    bus.credit_in   = '0;
  endtask

  task automatic set_in(input int unsigned i, input logic [2:0] route, input logic h, input logic t);
    bus.in_valid[i]         = 1'b1;
    bus.in_route[i]         = route;
    bus.in_preamble[i].head = h;
    bus.in_preamble[i].tail = t;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clr();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [2:0] cont_pop [4];
    cont_pop[0] = 3'b001;
    cont_pop[1] = 3'b010;
    cont_pop[2] = 3'b001;
    cont_pop[3] = 3'b010;

    rst = 1'b0;
    clr();

    // Reset state
    @(negedge clk); #1;
    chk("rst_pop",     32'(bus.in_pop), 32'h0);
    chk("rst_ovalid",  32'(bus.out_valid), 32'h0);
    chk("rst_osel",    32'(bus.out_sel), 32'h0);
    chk("rst_credits", 32'(bus.credits), 32'h124);
    chk("rst_err",     32'(bus.err), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Single-flit packets West->Local then East->Local
    @(negedge clk); clr(); set_in(0, kGoLocal, 1'b1, 1'b1); #1;
    chk("single_pop",    32'(bus.in_pop), 32'h1);
    chk("single_ovalid", 32'(bus.out_valid), 32'h4);
    chk("single_osel",   32'(bus.out_sel), 32'h0);
    @(negedge clk); clr(); set_in(1, kGoLocal, 1'b1, 1'b1); #1;
    chk("single_cred3",  32'(bus.credits[2]), 32'd3);
    chk("single2_pop",   32'(bus.in_pop), 32'h2);
    chk("single2_osel",  32'(bus.out_sel), 32'h10);
    @(negedge clk); clr(); #1;
    chk("single_cred2",  32'(bus.credits[2]), 32'd2);
    chk("single_idle",   32'(bus.out_valid), 32'h0);

    // Contention with constant credit return
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); clr();
      set_in(0, kGoLocal, 1'b1, 1'b1);
      set_in(1, kGoLocal, 1'b1, 1'b1);
      bus.credit_in[2] = 1'b1;
      #1;
      chk("cont_pop",  32'(bus.in_pop), 32'(cont_pop[k]));
      chk("cont_cred", 32'(bus.credits[2]), 32'd4);
    end
    @(negedge clk); clr(); #1;
    chk("cont_cred_end", 32'(bus.credits[2]), 32'd4);
    chk("cont_err",      32'(bus.err), 32'h0);

    // Wormhole: Local H/B/T to East, West single-flit to East from cycle 1
    do_reset();
    @(negedge clk); clr(); set_in(2, kGoEast, 1'b1, 1'b0); #1;
    chk("worm_h_pop",  32'(bus.in_pop), 32'h4);
    chk("worm_h_osel", 32'(bus.out_sel), 32'h08);
    @(negedge clk); clr(); set_in(2, kGoEast, 1'b0, 1'b0); set_in(0, kGoEast, 1'b1, 1'b1); #1;
    chk("worm_b_pop",  32'(bus.in_pop), 32'h4);
    @(negedge clk); clr(); set_in(2, kGoEast, 1'b0, 1'b1); set_in(0, kGoEast, 1'b1, 1'b1); #1;
    chk("worm_t_pop",  32'(bus.in_pop), 32'h4);
    @(negedge clk); clr(); set_in(0, kGoEast, 1'b1, 1'b1); #1;
    chk("worm_w_pop",    32'(bus.in_pop), 32'h1);
    chk("worm_w_ovalid", 32'(bus.out_valid), 32'h2);
    chk("worm_w_osel",   32'(bus.out_sel), 32'h0);
    @(negedge clk); clr(); #1;
    chk("worm_cred", 32'(bus.credits[1]), 32'd0);
    chk("worm_err",  32'(bus.err), 32'h0);

    // Credit exhaustion on West output
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); clr(); set_in(2, kGoWest, 1'b1, 1'b1); #1;
      chk("cred_grant", 32'(bus.in_pop), 32'h4);
    end
    @(negedge clk); clr(); set_in(2, kGoWest, 1'b1, 1'b1); #1;
    chk("cred_zero",  32'(bus.credits[0]), 32'd0);
    chk("cred_stall", 32'(bus.in_pop), 32'h0);
    @(negedge clk); clr(); set_in(2, kGoWest, 1'b1, 1'b1); bus.credit_in[0] = 1'b1; #1;
    chk("cred_same_cycle", 32'(bus.out_valid), 32'h0);
    @(negedge clk); clr(); set_in(2, kGoWest, 1'b1, 1'b1); #1;
    chk("cred_one",   32'(bus.credits[0]), 32'd1);
    chk("cred_fifth", 32'(bus.in_pop), 32'h4);
    @(negedge clk); clr(); #1;
    chk("cred_end", 32'(bus.credits[0]), 32'd0);
    chk("cred_err", 32'(bus.err), 32'h0);

    // Reset mid-packet
    do_reset();
    @(negedge clk); clr(); set_in(2, kGoEast, 1'b1, 1'b0); #1;
    chk("rmid_h_pop", 32'(bus.in_pop), 32'h4);
    @(negedge clk); clr(); set_in(2, kGoEast, 1'b0, 1'b0); rst = 1'b0; #1;
    chk("rmid_ovalid", 32'(bus.out_valid), 32'h0);
    chk("rmid_pop",    32'(bus.in_pop), 32'h0);
    chk("rmid_cred",   32'(bus.credits[1]), 32'd4);
    @(negedge clk); rst = 1'b1; clr(); set_in(0, kGoEast, 1'b1, 1'b1); #1;
    chk("rmid_new_pop",    32'(bus.in_pop), 32'h1);
    chk("rmid_new_ovalid", 32'(bus.out_valid), 32'h2);
    @(negedge clk); clr(); #1;
    chk("rmid_err",  32'(bus.err), 32'h0);
    chk("rmid_cred2", 32'(bus.credits[1]), 32'd3);

    // Error: non-head flit to an idle output, sticky
    do_reset();
    @(negedge clk); clr(); set_in(1, kGoLocal, 1'b0, 1'b0); #1;
    chk("err_nh_pop",    32'(bus.in_pop), 32'h0);
    chk("err_nh_ovalid", 32'(bus.out_valid), 32'h0);
    @(negedge clk); clr(); #1;
    chk("err_nh_flag", 32'(bus.err), 32'h1);
    @(negedge clk); #1;
    chk("err_nh_sticky", 32'(bus.err), 32'h1);

    // Error: U-turn East->East
    do_reset(); #1;
    chk("err_cleared", 32'(bus.err), 32'h0);
    @(negedge clk); clr(); set_in(1, kGoEast, 1'b1, 1'b1); #1;
    chk("err_ut_pop", 32'(bus.in_pop), 32'h0);
    @(negedge clk); clr(); #1;
    chk("err_ut_flag", 32'(bus.err), 32'h1);

    // Error: multi-hot route
    do_reset();
    @(negedge clk); clr(); set_in(0, 3'b011, 1'b1, 1'b1); #1;
    chk("err_mh_pop",    32'(bus.in_pop), 32'h0);
    chk("err_mh_ovalid", 32'(bus.out_valid), 32'h0);
    @(negedge clk); clr(); #1;
    chk("err_mh_flag", 32'(bus.err), 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("err_mh_sticky", 32'(bus.err), 32'h1);
    end

    // Error: head from owner while locked
    do_reset();
    @(negedge clk); clr(); set_in(2, kGoEast, 1'b1, 1'b0); #1;
    chk("err_lh_first", 32'(bus.in_pop), 32'h4);
    @(negedge clk); clr(); set_in(2, kGoEast, 1'b1, 1'b0); #1;
    chk("err_lh_pop", 32'(bus.in_pop), 32'h0);
    @(negedge clk); clr(); #1;
    chk("err_lh_flag", 32'(bus.err), 32'h1);

    // Error: credit return at full count saturates
    do_reset();
    @(negedge clk); clr(); bus.credit_in[0] = 1'b1; #1;
    @(negedge clk); clr(); #1;
    chk("err_ov_cred", 32'(bus.credits[0]), 32'd4);
    chk("err_ov_flag", 32'(bus.err), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ring_switch_allocator.md
Name: ring_switch_allocator

Overview:
- Per-router switch allocator for the ring NoC; sits between the three input FIFOs (West/East/Local) and the output crossbar.
- For each output port it arbitrates among requesting inputs using round-robin. It also holds a wormhole lock from head flit to tail flit.
- It tracks downstream credits, then drives input pop strobes and crossbar selects in the same cycle as the request.

Parameters:
- Ports, noc::AllPorts (3'b111), enabled-port mask indexed by noc_port_t; a disabled port is never granted as input or output.
- Depth, 4, downstream buffer depth in flits; each output's credit counter starts at this value.

Ports:
- clk  in  1  router clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  3  input i has a flit at FIFO head; index = noc_port_t.
- in_route  in  3x3  noc::direction_t per input; one-hot requested output; valid only with in_valid[i].
- in_preamble  in  3x2  noc::preamble_t per input (head, tail).
- in_pop  out  3  flit at input i transfers this cycle.
- out_valid  out  3  output j sends a flit this cycle.
- out_sel  out  3x2  noc_port_t of the input driving output j; value 0 when out_valid[j]=0.
- credit_in  in  1 per output (3)  downstream freed one slot at output j.
- credits  out  3x$clog2(Depth+1)  current credit count per output (debug and verification).
- err  out  1  sticky protocol-error flag; cleared only by reset.

Behaviour:
- Reset (rst=0, async):
  - all locks cleared; all credit counters = Depth; all round-robin pointers = kWestPort; err=0.
  - in_pop, out_valid and out_sel all drive 0 (they are combinational from cleared state).
- Latency: grant path is combinational; in_pop and out_valid assert in the same cycle as the qualifying in_valid. All state updates on the posedge clk.
- Request validity:
  - input i requests output j iff in_valid[i], in_route[i] is exactly one-hot at bit j, Ports[i] and Ports[j] are set, and i != j for East and West (no U-turn).
  - Any other in_valid[i] (zero-hot, multi-hot, disabled port, U-turn) gets no grant and sets err.
- Per-output state machine, state IDLE or LOCKED(owner):
  - IDLE:
    - only requests with head=1 are eligible.
    - the winner is the first eligible input in priority order p, p+1, p+2 (mod 3), where p is the pointer.
    - a grant additionally requires credits[j] > 0.
    - on a grant, p is set to winner+1 mod 3.
    - if head=1 and tail=0, go to LOCKED(winner); if head=1 and tail=1, stay IDLE.
    - a non-head flit requesting an IDLE output gets no grant and sets err.
  - LOCKED(o):
    - only input o is served, and only when credits[j] > 0; the pointer does not move.
    - a transferred flit with tail=1 returns the output to IDLE at the next cycle.
    - a head=1 flit from o while locked sets err and is not granted.
    - other inputs requesting j stall, with no error.
- Credits:
  - next = credits − (out_valid[j]) + (credit_in[j]).
  - a simultaneous send and credit return leaves the count unchanged.
  - credit_in while the count is at Depth (with no send) saturates the count and sets err.
  - the grant decision uses only the registered count; a same-cycle credit_in does not enable a grant at 0.
- An input requests one output per cycle, so it receives at most one grant. Different outputs grant independently in the same cycle.
- A lock persists through any number of credit-starved or in_valid=0 cycles.
- Reset mid-packet drops the lock with no flush; upstream and downstream reset together.

Decomposition:
- Add to the noc package:
  - the alloc_state_t enum (kAllocIdle, kAllocLocked);
  - a credit-count typedef parameterised by depth;
  - a next_rr_ptr function (noc_port_t in, noc_port_t out).
- Sub-module: noc_rr_arbiter3, a 3-requester round-robin arbiter with pointer input and one-hot grant output. Instantiate it once per output port.

Test Plan:
- Single-flit packets: West in_valid, route goLocal, head=1, tail=1 → same-cycle in_pop[0]=1, out_valid[2]=1, out_sel[2]=kWestPort; credits[2] goes 4→3; no lock.
- Contention: West and East both send head+tail single flits to Local every cycle with credit_in[2]=1 every cycle → grants alternate West, East, West…; credits stay constant at 4.
- Wormhole: Local sends a 3-flit packet (H, body, T) to East while West sends a single-flit packet to East starting cycle 1 → West stalls until the cycle after T; West is granted on cycle 3.
- Credit exhaustion: Depth=4, no credit_in, 5 flits to West → 4 grants, credits=0, 5th stalls. Then credit_in=1 for one cycle → 5th granted the cycle after.
- Errors: non-head flit to an idle output → no grant, err=1. East input routed to East (U-turn) → no grant, err=1. Multi-hot route 3'b011 → no grant, err=1. err stays 1 until rst.
- Reset mid-packet: assert rst between H and T of a locked packet → out_valid=0 immediately, credits=4 and output IDLE after release; a new head from a different input is granted on the first cycle.
